// File: rtl/logic_capture_pkg.sv
// Shared types and constants for the logic_capture engine.
package logic_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRIGD = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LVL_W      = $clog2(NUM_LEVELS);

  typedef logic [LVL_W-1:0] lvl_t;

  // Per-bit trigger type encodings.
  localparam logic LEVEL = 1'b0;
  localparam logic EDGE  = 1'b1;

endpackage

// File: rtl/logic_capture_trig_match.sv
// Single trigger level: every masked bit must meet its level or edge condition.
module trig_match
  import logic_capture_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic [size-1:0] mask,
  input  logic [size-1:0] trig_type,
  input  logic [size-1:0] level,
  input  logic [size-1:0] cur,
  input  logic [size-1:0] prev,
  output logic            match
);

  // AND of per-bit conditions; unmasked bits are don't-care.
  always_comb begin
    match = 1'b1;
    for (int unsigned i = 0; i < size; i++) begin
      if (mask[i]) begin
        if (trig_type[i] == LEVEL) begin
          if (cur[i] != level[i]) match = 1'b0;
        end else if (level[i]) begin
          if (!(!prev[i] && cur[i])) match = 1'b0;
        end else begin
          if (!(prev[i] && !cur[i])) match = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/logic_capture.sv
// Logic-analyzer capture engine: divided-rate sampling, 8-level sequential
// trigger, post-trigger count, AXI-Stream sample output.
module logic_capture
  import logic_capture_pkg::*;
#(
  parameter int unsigned size    = 32,
  parameter int unsigned max_div = 32,
  parameter int unsigned saddr_w = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [size-1:0]            dinput,
  input  logic [$clog2(max_div)-1:0] ckdiv,
  input  logic                       arm,
  input  logic                       abort,
  input  logic [size-1:0]            trig_level1_mask,
  input  logic [size-1:0]            trig_level1_type,
  input  logic [size-1:0]            trig_level1_level,
  input  logic [size-1:0]            trig_level2_mask,
  input  logic [size-1:0]            trig_level2_type,
  input  logic [size-1:0]            trig_level2_level,
  input  logic [size-1:0]            trig_level3_mask,
  input  logic [size-1:0]            trig_level3_type,
  input  logic [size-1:0]            trig_level3_level,
  input  logic [size-1:0]            trig_level4_mask,
  input  logic [size-1:0]            trig_level4_type,
  input  logic [size-1:0]            trig_level4_level,
  input  logic [size-1:0]            trig_level5_mask,
  input  logic [size-1:0]            trig_level5_type,
  input  logic [size-1:0]            trig_level5_level,
  input  logic [size-1:0]            trig_level6_mask,
  input  logic [size-1:0]            trig_level6_type,
  input  logic [size-1:0]            trig_level6_level,
  input  logic [size-1:0]            trig_level7_mask,
  input  logic [size-1:0]            trig_level7_type,
  input  logic [size-1:0]            trig_level7_level,
  input  logic [size-1:0]            trig_level8_mask,
  input  logic [size-1:0]            trig_level8_type,
  input  logic [size-1:0]            trig_level8_level,
  input  logic [saddr_w-1:0]         post_trigger_count,
  input  logic [saddr_w-1:0]         buffer_size,
  output logic [size-1:0]            tdata,
  output logic                       tvalid,
  input  logic                       tready,
  output logic                       srst,
  output logic                       overrun,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic                       ready,
  output logic [saddr_w-1:0]         trigger_pos
);

  localparam int unsigned DIV_W = $clog2(max_div);

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [saddr_w-1:0] wr_idx;
  logic [saddr_w-1:0] post_cnt;
  lvl_t               lvl, lvl_next;
  logic [size-1:0]    prev_sample;
  logic               first_strobe;

  logic [size-1:0]       trig_mask [NUM_LEVELS];
  logic [size-1:0]       trig_type [NUM_LEVELS];
  logic [size-1:0]       trig_lvl  [NUM_LEVELS];
  logic [NUM_LEVELS-1:0] level_match;
  logic [size-1:0]       prev_eff;

  logic active, rearm, abort_now, post_full, running, strobe, capture;
  logic last_level, fire, advance;

  assign trig_mask[0] = trig_level1_mask;
  assign trig_mask[1] = trig_level2_mask;
  assign trig_mask[2] = trig_level3_mask;
  assign trig_mask[3] = trig_level4_mask;
  assign trig_mask[4] = trig_level5_mask;
  assign trig_mask[5] = trig_level6_mask;
  assign trig_mask[6] = trig_level7_mask;
  assign trig_mask[7] = trig_level8_mask;
  assign trig_type[0] = trig_level1_type;
  assign trig_type[1] = trig_level2_type;
  assign trig_type[2] = trig_level3_type;
  assign trig_type[3] = trig_level4_type;
  assign trig_type[4] = trig_level5_type;
  assign trig_type[5] = trig_level6_type;
  assign trig_type[6] = trig_level7_type;
  assign trig_type[7] = trig_level8_type;
  assign trig_lvl[0]  = trig_level1_level;
  assign trig_lvl[1]  = trig_level2_level;
  assign trig_lvl[2]  = trig_level3_level;
  assign trig_lvl[3]  = trig_level4_level;
  assign trig_lvl[4]  = trig_level5_level;
  assign trig_lvl[5]  = trig_level6_level;
  assign trig_lvl[6]  = trig_level7_level;
  assign trig_lvl[7]  = trig_level8_level;

  // The first strobe after arm compares against itself so no edge is seen.
  assign prev_eff = first_strobe ? dinput : prev_sample;

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_match
    trig_match #(.size(size)) u_match (
      .mask      (trig_mask[g]),
      .trig_type (trig_type[g]),
      .level     (trig_lvl[g]),
      .cur       (dinput),
      .prev      (prev_eff),
      .match     (level_match[g])
    );
  end

  assign active    = (state == ARMED) || (state == TRIGD);
  assign rearm     = arm && ((state == IDLE) || (state == DONE));
  assign abort_now = abort && active;
  assign post_full = (post_cnt == post_trigger_count);
  // Once the post-trigger quota is met, strobing stops while the final
  // sample drains through the handshake.
  assign running   = (state == ARMED) || ((state == TRIGD) && !post_full);
  assign strobe    = running && !abort && (div_cnt == ckdiv);
  assign capture   = strobe && (!tvalid || tready);

  assign lvl_next   = lvl + 1'b1;
  assign last_level = (lvl == lvl_t'(NUM_LEVELS - 1)) || (trig_mask[lvl_next] == '0);
  assign fire       = capture && (state == ARMED) && level_match[lvl] && last_level;
  assign advance    = capture && (state == ARMED) && level_match[lvl] && !last_level;

  assign ready     = (state == IDLE) || (state == DONE);
  assign armed     = (state == ARMED);
  assign triggered = (state == TRIGD);
  assign done      = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort outranks arm and trigger.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (arm) state_next = ARMED;
      ARMED: begin
        if (abort)     state_next = IDLE;
        else if (fire) state_next = TRIGD;
      end
      TRIGD: begin
        if (abort)                               state_next = IDLE;
        else if (post_full && (!tvalid || tready)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample datapath: divider, capture, handshake, indices and trigger level.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      wr_idx       <= '0;
      post_cnt     <= '0;
      lvl          <= '0;
      prev_sample  <= '0;
      first_strobe <= 1'b1;
      tdata        <= '0;
      tvalid       <= 1'b0;
      srst         <= 1'b0;
      overrun      <= 1'b0;
      trigger_pos  <= '0;
    end else begin
      srst <= 1'b0;
      if (tvalid && tready) tvalid <= 1'b0;
      if (rearm) begin
        srst         <= 1'b1;
        overrun      <= 1'b0;
        trigger_pos  <= '0;
        wr_idx       <= '0;
        post_cnt     <= '0;
        lvl          <= '0;
        div_cnt      <= '0;
        first_strobe <= 1'b1;
      end else if (abort_now) begin
        tvalid  <= 1'b0;
        div_cnt <= '0;
      end else begin
        if (running) div_cnt <= strobe ? '0 : div_cnt + 1'b1;
        if (strobe) begin
          prev_sample  <= dinput;
          first_strobe <= 1'b0;
          if (tvalid && !tready) overrun <= 1'b1;
        end
        if (capture) begin
          tdata  <= dinput;
          tvalid <= 1'b1;
          wr_idx <= (wr_idx >= buffer_size - 1'b1) ? '0 : wr_idx + 1'b1;
          if (state == TRIGD) post_cnt <= post_cnt + 1'b1;
        end
        if (fire) begin
          trigger_pos <= wr_idx;
          post_cnt    <= '0;
        end else if (advance) begin
          lvl <= lvl_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_capture.sv
// Directed self-checking bench for logic_capture.
module tb_logic_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dinput;
  logic [4:0]  ckdiv;
  logic        arm, abort, tready;
  logic [31:0] m [8];
  logic [31:0] t [8];
  logic [31:0] l [8];
  logic [23:0] post_trigger_count, buffer_size;
  logic [31:0] tdata;
  logic        tvalid, srst, overrun, armed, triggered, done, ready;
  logic [23:0] trigger_pos;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic_capture #(.size(32), .max_div(32), .saddr_w(24)) dut (
    .clk(clk), .reset(reset), .dinput(dinput), .ckdiv(ckdiv),
    .arm(arm), .abort(abort),
    .trig_level1_mask(m[0]), .trig_level1_type(t[0]), .trig_level1_level(l[0]),
    .trig_level2_mask(m[1]), .trig_level2_type(t[1]), .trig_level2_level(l[1]),
    .trig_level3_mask(m[2]), .trig_level3_type(t[2]), .trig_level3_level(l[2]),
    .trig_level4_mask(m[3]), .trig_level4_type(t[3]), .trig_level4_level(l[3]),
    .trig_level5_mask(m[4]), .trig_level5_type(t[4]), .trig_level5_level(l[4]),
    .trig_level6_mask(m[5]), .trig_level6_type(t[5]), .trig_level6_level(l[5]),
    .trig_level7_mask(m[6]), .trig_level7_type(t[6]), .trig_level7_level(l[6]),
    .trig_level8_mask(m[7]), .trig_level8_type(t[7]), .trig_level8_level(l[7]),
    .post_trigger_count(post_trigger_count), .buffer_size(buffer_size),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .srst(srst),
    .overrun(overrun), .armed(armed), .triggered(triggered), .done(done),
    .ready(ready), .trigger_pos(trigger_pos)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and advance to just after the edge that strobes it.
  task automatic strobe_in(input logic [31:0] val);
    dinput = val;
    repeat (int'(ckdiv) + 1) tick();
  endtask

  task automatic clear_levels();
    for (int i = 0; i < 8; i++) begin
      m[i] = '0;
      t[i] = '0;
      l[i] = '0;
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dinput = '0; ckdiv = '0; arm = 1'b0; abort = 1'b0; tready = 1'b1;
    post_trigger_count = '0; buffer_size = 24'd128;
    clear_levels();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_armed", 32'(armed), 32'd0);
    check_eq("rst_trig", 32'(triggered), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_tdata", tdata, 32'd0);
    check_eq("rst_tpos", 32'(trigger_pos), 32'd0);

    // Single-level level trigger, ckdiv=1, post=3
    ckdiv = 5'd1; post_trigger_count = 24'd3; buffer_size = 24'd128;
    m[0] = 32'h1; t[0] = 32'h0; l[0] = 32'h1;
    dinput = 32'h0;
    do_arm();
    check_eq("t1_srst", 32'(srst), 32'd1);
    check_eq("t1_armed", 32'(armed), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      strobe_in(32'h100 * k);
      check_eq("t1_pre_tdata", tdata, 32'h100 * k);
      check_eq("t1_pre_armed", 32'(armed), 32'd1);
    end
    strobe_in(32'h501);
    check_eq("t1_trig_tdata", tdata, 32'h501);
    check_eq("t1_triggered", 32'(triggered), 32'd1);
    check_eq("t1_tpos", 32'(trigger_pos), 32'd4);
    for (int k = 6; k <= 8; k++) begin
      strobe_in(32'h1000 + k);
      check_eq("t1_post_tdata", tdata, 32'h1000 + k);
      check_eq("t1_post_done", 32'(done), 32'd0);
    end
    tick();
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_ready", 32'(ready), 32'd1);
    check_eq("t1_tvalid_end", 32'(tvalid), 32'd0);
    repeat (4) tick();
    check_eq("t1_no_more", 32'(tvalid), 32'd0);

    // Two-level sequence: rising bit0 then bit1 high
    clear_levels();
    ckdiv = 5'd0; post_trigger_count = 24'd0;
    m[0] = 32'h1; t[0] = 32'h1; l[0] = 32'h1;
    m[1] = 32'h2; t[1] = 32'h0; l[1] = 32'h2;
    dinput = 32'h3;
    do_arm();
    check_eq("t2_tpos_clr", 32'(trigger_pos), 32'd0);
    dinput = 32'h3; tick();
    check_eq("t2_s1_armed", 32'(armed), 32'd1);
    strobe_in(32'h2);
    check_eq("t2_s2_armed", 32'(armed), 32'd1);
    strobe_in(32'h1);
    check_eq("t2_s3_armed", 32'(armed), 32'd1);
    strobe_in(32'h0);
    check_eq("t2_s4_armed", 32'(armed), 32'd1);
    strobe_in(32'h2);
    check_eq("t2_triggered", 32'(triggered), 32'd1);
    check_eq("t2_tdata", tdata, 32'h2);
    check_eq("t2_tpos", 32'(trigger_pos), 32'd4);
    tick();
    check_eq("t2_done", 32'(done), 32'd1);

    // Buffer wrap: buffer_size=4, trigger on 10th strobe
    clear_levels();
    ckdiv = 5'd0; post_trigger_count = 24'd0; buffer_size = 24'd4;
    m[0] = 32'h1; t[0] = 32'h0; l[0] = 32'h1;
    dinput = 32'h0;
    do_arm();
    for (int k = 1; k <= 9; k++) strobe_in(32'h10 * k);
    check_eq("t3_pre_armed", 32'(armed), 32'd1);
    strobe_in(32'hA1);
    check_eq("t3_triggered", 32'(triggered), 32'd1);
    check_eq("t3_tpos", 32'(trigger_pos), 32'd1);
    tick();
    check_eq("t3_done", 32'(done), 32'd1);

    // Overrun with tready held low
    buffer_size = 24'd128;
    tready = 1'b0;
    dinput = 32'h0;
    do_arm();
    strobe_in(32'h10);
    check_eq("t4_tvalid", 32'(tvalid), 32'd1);
    check_eq("t4_ovr_before", 32'(overrun), 32'd0);
    strobe_in(32'h20);
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    check_eq("t4_tdata_hold", tdata, 32'h10);
    check_eq("t4_still_armed", 32'(armed), 32'd1);

    // Abort during ARMED, then re-arm clears overrun
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t5_ready", 32'(ready), 32'd1);
    check_eq("t5_armed", 32'(armed), 32'd0);
    check_eq("t5_tvalid", 32'(tvalid), 32'd0);
    check_eq("t5_ovr_sticky", 32'(overrun), 32'd1);
    do_arm();
    check_eq("t5_srst", 32'(srst), 32'd1);
    check_eq("t5_ovr_clr", 32'(overrun), 32'd0);
    check_eq("t5_rearmed", 32'(armed), 32'd1);
    tick();
    check_eq("t5_srst_pulse", 32'(srst), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tready = 1'b1;
    check_eq("t5_idle", 32'(ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
